// File: rtl/trc_config_pkg.sv
// Shared definitions for the transceiver configuration sequencer.
package trc_config_pkg;

    localparam int unsigned IDX_W  = 6;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned POLL_W = 10;

    // Reconfig controller register offsets
    localparam logic [ADDR_W-1:0] PMA_CH_NR  = 7'h08;
    localparam logic [ADDR_W-1:0] PMA_STATUS = 7'h0A;
    localparam logic [ADDR_W-1:0] PMA_OFFSET = 7'h0B;
    localparam logic [ADDR_W-1:0] PMA_DATA   = 7'h0C;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WRITE  = 3'd2,
        ST_READ   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_NEXT   = 3'd5,
        ST_FINISH = 3'd6,
        ST_FAIL   = 3'd7
    } state_t;

    // Management bus request captured from the table
    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] writedata;
    } mgmt_req_t;

    // Poll counter increment that sticks at all-ones instead of wrapping
    function automatic logic [POLL_W-1:0] poll_inc(input logic [POLL_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + POLL_W'(1);
    endfunction

endpackage

// File: rtl/trc_config_ctrl.sv
// Walks an external configuration table, issuing Avalon-MM writes and status polls.
module trc_config_ctrl
    import trc_config_pkg::*;
#(
    parameter int unsigned LAST_INDEX = 18,
    parameter int unsigned POLL_LIMIT = 1023,
    parameter int unsigned BUSY_BIT   = 8,
    parameter int unsigned ERR_BIT    = 9
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    output logic [IDX_W-1:0]     lut_index,
    input  logic [7:0]           lut_address,
    input  logic [DATA_W-1:0]    lut_data,
    input  logic                 lut_wr,
    output logic [ADDR_W-1:0]    mgmt_address,
    output logic                 mgmt_write,
    output logic                 mgmt_read,
    output logic [DATA_W-1:0]    mgmt_writedata,
    input  logic [DATA_W-1:0]    mgmt_readdata,
    input  logic                 mgmt_waitrequest,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    state_t            state_q;
    state_t            state_d;
    logic [IDX_W-1:0]  index_d;
    logic [POLL_W-1:0] poll_cnt_q;
    logic [POLL_W-1:0] poll_cnt_d;
    mgmt_req_t         req_q;
    mgmt_req_t         req_d;
    logic              sts_busy_q;
    logic              sts_busy_d;
    logic              sts_err_q;
    logic              sts_err_d;
    logic              write_d;
    logic              read_d;
    logic              busy_d;
    logic              done_d;
    logic              error_d;

    // Table address MSB and non-status readdata bits carry no meaning here
    logic unused_bits;
    assign unused_bits = ^{lut_address[7], mgmt_readdata};

    assign mgmt_address   = req_q.address;
    assign mgmt_writedata = req_q.writedata;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and next values of every registered output
    always_comb begin
        state_d    = state_q;
        index_d    = lut_index;
        poll_cnt_d = poll_cnt_q;
        req_d      = req_q;
        sts_busy_d = sts_busy_q;
        sts_err_d  = sts_err_q;
        error_d    = error;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    index_d = '0;
                    error_d = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                req_d.address   = lut_address[ADDR_W-1:0];
                req_d.writedata = lut_data;
                if (lut_wr) begin
                    state_d = ST_WRITE;
                end else begin
                    poll_cnt_d = '0;
                    state_d    = ST_READ;
                end
            end
            ST_WRITE: begin
                if (!mgmt_waitrequest) begin
                    state_d = ST_NEXT;
                end
            end
            ST_READ: begin
                if (!mgmt_waitrequest) begin
                    sts_busy_d = mgmt_readdata[BUSY_BIT];
                    sts_err_d  = mgmt_readdata[ERR_BIT];
                    state_d    = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (sts_err_q) begin
                    state_d = ST_FAIL;
                end else if (!sts_busy_q) begin
                    state_d = ST_NEXT;
                end else if (poll_cnt_q == POLL_W'(POLL_LIMIT)) begin
                    state_d = ST_FAIL;
                end else begin
                    poll_cnt_d = poll_inc(poll_cnt_q);
                    state_d    = ST_READ;
                end
            end
            ST_NEXT: begin
                if (lut_index == IDX_W'(LAST_INDEX)) begin
                    state_d = ST_FINISH;
                end else begin
                    index_d = lut_index + IDX_W'(1);
                    state_d = ST_FETCH;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            ST_FAIL:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // Outputs follow the state being entered so they are valid from its first cycle
        write_d = (state_d == ST_WRITE);
        read_d  = (state_d == ST_READ);
        done_d  = (state_d == ST_FINISH);
        busy_d  = (state_d == ST_FETCH) || (state_d == ST_WRITE) || (state_d == ST_READ) ||
                  (state_d == ST_CHECK) || (state_d == ST_NEXT);
        if (state_d == ST_FAIL) begin
            error_d = 1'b1;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lut_index  <= '0;
            poll_cnt_q <= '0;
            req_q      <= '0;
            sts_busy_q <= 1'b0;
            sts_err_q  <= 1'b0;
            mgmt_write <= 1'b0;
            mgmt_read  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            lut_index  <= index_d;
            poll_cnt_q <= poll_cnt_d;
            req_q      <= req_d;
            sts_busy_q <= sts_busy_d;
            sts_err_q  <= sts_err_d;
            mgmt_write <= write_d;
            mgmt_read  <= read_d;
            busy       <= busy_d;
            done       <= done_d;
            error      <= error_d;
        end
    end

endmodule

// File: tb/tb_trc_config_ctrl.sv
// Randomized self-checking bench: table + Avalon slave model, transaction-level reference.
module tb_trc_config_ctrl;
    import trc_config_pkg::*;

    localparam int LAST  = 18;
    localparam int LIMIT = 1023;
    localparam int BUDGET = 5000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [5:0]  lut_index;
    logic [7:0]  lut_address;
    logic [31:0] lut_data;
    logic        lut_wr;
    logic [6:0]  mgmt_address;
    logic        mgmt_write;
    logic        mgmt_read;
    logic [31:0] mgmt_writedata;
    logic [31:0] mgmt_readdata;
    logic        mgmt_waitrequest;
    logic        busy;
    logic        done;
    logic        error;

    trc_config_ctrl #(.LAST_INDEX(LAST), .POLL_LIMIT(LIMIT), .BUSY_BIT(8), .ERR_BIT(9)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .lut_index(lut_index),
        .lut_address(lut_address), .lut_data(lut_data), .lut_wr(lut_wr),
        .mgmt_address(mgmt_address), .mgmt_write(mgmt_write), .mgmt_read(mgmt_read),
        .mgmt_writedata(mgmt_writedata), .mgmt_readdata(mgmt_readdata),
        .mgmt_waitrequest(mgmt_waitrequest), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_wr;
        logic [6:0]  addr;
        logic [31:0] data;
        logic [5:0]  idx;
    } xfer_t;

    xfer_t act_q[$];
    xfer_t exp_q[$];
    int checks = 0;
    int failures = 0;

    // Configuration table contents and scenario knobs
    logic [7:0]  tbl_addr [0:LAST];
    logic [31:0] tbl_data [0:LAST];
    logic        tbl_wr   [0:LAST];
    int poll_busy [0:LAST];
    int rd_k      [0:LAST];
    int stall_idx = -1;
    int stall_len = 0;
    bit rand_stall = 0;
    int err_idx = -1;
    int stuck_idx = -1;
    int hold3 = -1;
    int done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Status word the slave returns for the k-th read of entry idx
    function automatic logic [31:0] response(input int idx, input int k);
        if (idx == err_idx) return 32'h200;
        if (idx == stuck_idx) return 32'h100;
        return (k < poll_busy[idx]) ? 32'h100 : 32'h0;
    endfunction

    // External table: combinational lookup on lut_index
    always_comb begin
        lut_address = 8'h00;
        lut_data    = 32'h0;
        lut_wr      = 1'b0;
        if (int'(lut_index) <= LAST) begin
            lut_address = tbl_addr[int'(lut_index)];
            lut_data    = tbl_data[int'(lut_index)];
            lut_wr      = tbl_wr[int'(lut_index)];
        end
    end

    // Slave model, transfer logger and per-cycle bus checks
    bit          in_xfer = 0;
    int          stall_left = 0;
    int          hold = 0;
    logic [39:0] cap;
    always @(negedge clk) begin
        if (!reset_n) begin
            mgmt_waitrequest = 1'b0;
            in_xfer = 0;
        end else begin
            check("strobe_exclusive", 64'(mgmt_write && mgmt_read), 64'd0);
            check("strobe_while_idle", 64'(!busy && (mgmt_write || mgmt_read)), 64'd0);
            if (done) begin
                done_cnt++;
                check("busy_with_done", 64'(busy), 64'd0);
            end
            if (mgmt_write || mgmt_read) begin
                if (!in_xfer) begin
                    in_xfer = 1;
                    hold = 0;
                    cap = {mgmt_write, mgmt_address, mgmt_writedata};
                    if (int'(lut_index) == stall_idx) stall_left = stall_len;
                    else stall_left = rand_stall ? int'($urandom_range(0, 3)) : 0;
                end else begin
                    check("stall_hold", 64'({mgmt_write, mgmt_address, mgmt_writedata}), 64'(cap));
                end
                hold++;
                if (stall_left > 0) begin
                    mgmt_waitrequest = 1'b1;
                    mgmt_readdata = $urandom;
                    stall_left--;
                end else begin
                    mgmt_waitrequest = 1'b0;
                    in_xfer = 0;
                    if (mgmt_write) begin
                        act_q.push_back({1'b1, mgmt_address, mgmt_writedata, lut_index});
                        if (int'(lut_index) == 3) hold3 = hold;
                    end else if (int'(lut_index) <= LAST) begin
                        mgmt_readdata = response(int'(lut_index), rd_k[int'(lut_index)]);
                        rd_k[int'(lut_index)]++;
                        act_q.push_back({1'b0, mgmt_address, mgmt_readdata, lut_index});
                    end
                end
            end else begin
                mgmt_waitrequest = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic setup_table(input bit rnd);
        for (int i = 0; i <= LAST; i++) begin
            logic [6:0] a;
            tbl_wr[i] = !(i == 2 || i == 9 || i == 17);
            if (!tbl_wr[i]) a = PMA_STATUS;
            else if (i == 3) a = PMA_DATA;
            else if (i % 3 == 0) a = PMA_CH_NR;
            else if (i % 3 == 1) a = PMA_OFFSET;
            else a = PMA_DATA;
            tbl_addr[i] = {1'($urandom_range(0, 1)), a};
            tbl_data[i] = (i == 3) ? 32'h0000000A : (rnd ? $urandom : 32'h100 + 32'(i));
            poll_busy[i] = 0;
        end
        stall_idx = -1;
        stall_len = 0;
        rand_stall = 0;
        err_idx = -1;
        stuck_idx = -1;
    endtask

    // Reference: walk the table in order; poll until not busy, bounded by LIMIT+1 reads
    task automatic build_exp(output bit exp_fail);
        exp_q.delete();
        exp_fail = 0;
        for (int i = 0; i <= LAST && !exp_fail; i++) begin
            if (tbl_wr[i]) begin
                exp_q.push_back({1'b1, tbl_addr[i][6:0], tbl_data[i], 6'(i)});
            end else begin
                for (int k = 0; ; k++) begin
                    logic [31:0] r;
                    r = response(i, k);
                    exp_q.push_back({1'b0, tbl_addr[i][6:0], r, 6'(i)});
                    if (r[9]) begin exp_fail = 1; break; end
                    if (!r[8]) break;
                    if (k + 1 == LIMIT + 1) begin exp_fail = 1; break; end
                end
            end
        end
    endtask

    function automatic int count_x(input int want_wr, input int want_idx);
        int n = 0;
        foreach (act_q[i]) begin
            if ((want_wr < 0 || int'(act_q[i].is_wr) == want_wr) &&
                (want_idx < 0 || int'(act_q[i].idx) == want_idx)) n++;
        end
        return n;
    endfunction

    task automatic clear_run();
        act_q.delete();
        for (int i = 0; i <= LAST; i++) rd_k[i] = 0;
        done_cnt = 0;
        hold3 = -1;
    endtask

    task automatic run(input string tag, input bit start_at_done);
        int cyc;
        bit exp_fail;
        logic got_done;
        clear_run();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check({tag, "_busy_after_start"}, 64'(busy), 64'd1);
        check({tag, "_error_cleared"}, 64'(error), 64'd0);
        cyc = 0;
        while (!done && !error && cyc < BUDGET) begin
            start = (cyc == 10 && busy);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, "_finished_in_budget"}, 64'(cyc < BUDGET), 64'd1);
        got_done = done;
        if (start_at_done && done) begin
            start = 1'b1;
            @(negedge clk) start = 1'b0;
        end
        repeat (3) @(negedge clk);
        build_exp(exp_fail);
        check({tag, "_done_seen"}, 64'(got_done), 64'(!exp_fail));
        check({tag, "_error"}, 64'(error), 64'(exp_fail));
        check({tag, "_busy_end"}, 64'(busy), 64'd0);
        check({tag, "_done_pulses"}, 64'(done_cnt), exp_fail ? 64'd0 : 64'd1);
        check({tag, "_xfer_count"}, 64'(act_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_xfer%0d", tag, i), 64'(act_q[i]), 64'(exp_q[i]));
    endtask

    initial begin
        int cyc;
        reset_n = 1'b0;
        start = 1'b0;
        mgmt_readdata = 32'h0;
        mgmt_waitrequest = 1'b0;
        setup_table(0);
        repeat (3) @(negedge clk);
        check("rst_index", 64'(lut_index), 64'd0);
        check("rst_strobes", 64'({mgmt_write, mgmt_read}), 64'd0);
        check("rst_bus", 64'({mgmt_address, mgmt_writedata}), 64'd0);
        check("rst_flags", 64'({busy, done, error}), 64'd0);
        #2 reset_n = 1'b1;

        // Nominal, with a start in the done cycle that must be ignored
        run("nominal", 1);
        check("nominal_writes", 64'(count_x(1, -1)), 64'd16);
        check("nominal_reads", 64'(count_x(0, -1)), 64'd3);
        check("nominal_hold3", 64'(hold3), 64'd1);

        // Stall on entry 3
        setup_table(0);
        stall_idx = 3;
        stall_len = 5;
        run("stall", 0);
        check("stall_hold3", 64'(hold3), 64'd6);
        foreach (act_q[i]) if (act_q[i].idx == 6'd3)
            check("stall_entry3", 64'({act_q[i].addr, act_q[i].data}), 64'({7'h0C, 32'h0000000A}));

        // Busy polling on entry 17
        setup_table(0);
        poll_busy[17] = 3;
        run("poll", 0);
        check("poll_reads17", 64'(count_x(0, 17)), 64'd4);

        // Status stuck busy on entry 2
        setup_table(0);
        stuck_idx = 2;
        run("timeout", 0);
        check("timeout_reads", 64'(count_x(0, 2)), 64'd1024);
        check("timeout_writes", 64'(count_x(1, -1)), 64'd2);

        // Error bit on entry 9
        setup_table(0);
        err_idx = 9;
        run("errbit", 0);
        check("errbit_writes", 64'(count_x(1, -1)), 64'd8);
        check("errbit_no_entry10", 64'(count_x(-1, 10)), 64'd0);

        // Reset during a long write stall, then a clean re-run
        setup_table(0);
        stall_idx = 3;
        stall_len = 40;
        clear_run();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 0;
        while (!(mgmt_write && lut_index == 6'd3) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_reach_stall", 64'(cyc < 200), 64'd1);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_strobes", 64'({mgmt_write, mgmt_read}), 64'd0);
        check("midrst_bus", 64'({mgmt_address, mgmt_writedata}), 64'd0);
        check("midrst_flags", 64'({busy, done, error}), 64'd0);
        check("midrst_index", 64'(lut_index), 64'd0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("postrst_no_resume", 64'({mgmt_write, mgmt_read, busy}), 64'd0);
        stall_idx = -1;
        run("rerun", 0);

        // Randomized tables, stalls, polling and occasional error status
        for (int r = 0; r < 4; r++) begin
            setup_table(1);
            rand_stall = 1;
            poll_busy[2]  = int'($urandom_range(0, 3));
            poll_busy[9]  = int'($urandom_range(0, 3));
            poll_busy[17] = int'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: err_idx = 9;
                1: err_idx = 17;
                default: err_idx = -1;
            endcase
            run($sformatf("rand%0d", r), r[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
